v74x139_enc: RTL and testbench



---
 rtl/v74x139_enc_pkg.sv | 33 +++
 rtl/v74x139_enc_chan.sv | 144 ++++++++++++++
 rtl/v74x139_enc.sv | 76 +++++++
 tb/tb_v74x139_enc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/v74x139_enc_pkg.sv
// v74x139_enc_pkg
// Shared definitions for the dual 4-to-2 registered priority encoder:
// channel FSM state encoding, the idle request pattern, the code width,
// and the combinational helpers used to encode a qualified pattern.
package v74x139_enc_pkg;

  localparam int CODE_W = 2;
  localparam logic [3:0] IDLE_PATTERN = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    VALID   = 2'd2,
    RELEASE = 2'd3
  } chan_state_e;

  // Index of the highest-numbered asserted (0) line. The loop runs upward,
  // so higher bits overwrite lower ones and bit 3 wins.
  function automatic logic [CODE_W-1:0] enc(input logic [3:0] pat);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (!pat[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  // More than one line asserted at the same time.
  function automatic logic is_multi(input logic [3:0] pat);
    return $countones(~pat) > 1;
  endfunction

endpackage

// File: rtl/v74x139_enc_chan.sv
// v74x139_enc_chan
// One encoder channel: input synchronizer, stability counter, FSM and
// priority encoder.
//
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   req_l[3:0] : active-low request lines, bit 3 highest priority
//   ack        : acknowledge, releases a reported code
//   code[1:0]  : {B,A} index of the qualified request, frozen while valid
//   valid      : code valid
//   multi      : more than one line was asserted at qualification
//                (only when V74X139_ENC_MULTI_EN is defined)
module v74x139_enc_chan
  import v74x139_enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req_l,
  input  logic              ack,
  output logic [CODE_W-1:0] code,
  output logic              valid
`ifdef V74X139_ENC_MULTI_EN
  ,
  output logic              multi
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  s;

  // NOTE: the synchronizer is a reset shift register, not a memory; clearing
  // it to the idle pattern keeps a stale request from qualifying after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_PATTERN}};
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, giving a true SYNC_STAGES-deep pipeline.
      sync_q[0] <= req_l;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  chan_state_e       state_q, state_d;
  logic [3:0]        pat_q, pat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
`ifdef V74X139_ENC_MULTI_EN
  logic              multi_q, multi_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= IDLE_PATTERN;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
`ifdef V74X139_ENC_MULTI_EN
      multi_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
`ifdef V74X139_ENC_MULTI_EN
      multi_q <= multi_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to "hold" first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
`ifdef V74X139_ENC_MULTI_EN
    multi_d = multi_q;
`endif
    case (state_q)
      IDLE: begin
        if (s != IDLE_PATTERN) begin
          pat_d   = s;
          cnt_d   = CNT_W'(1);
          state_d = QUAL;
        end
      end
      QUAL: begin
        if (s == IDLE_PATTERN) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (s != pat_q) begin
          // A different non-idle pattern restarts qualification on it.
          pat_d = s;
          cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
          code_d  = enc(pat_q);
          valid_d = 1'b1;
`ifdef V74X139_ENC_MULTI_EN
          multi_d = is_multi(pat_q);
`endif
          state_d = VALID;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      VALID: begin
        if (ack) begin
          valid_d = 1'b0;
`ifdef V74X139_ENC_MULTI_EN
          multi_d = 1'b0;
`endif
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // The held request must go idle before anything new is reported.
        if (s == IDLE_PATTERN) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign code  = code_q;
  assign valid = valid_q;
`ifdef V74X139_ENC_MULTI_EN
  assign multi = multi_q;
`endif

endmodule

// File: rtl/v74x139_enc.sv
// v74x139_enc
// Dual 4-to-2 registered priority encoder with stability qualification and
// acknowledge handshake. Two independent channels share only CLK/RESET_L.
//
// Ports:
//   CLK, RESET_L   : clock (rising edge), asynchronous active-low reset
//   I1_L, I2_L     : active-low request lines, bit 3 highest priority
//   ACK1, ACK2     : per-channel acknowledge
//   B1/A1, B2/A2   : per-channel code {B,A}
//   V1, V2         : per-channel code valid
//   M1, M2         : multiple-request flag (V74X139_ENC_MULTI_EN only)
//
// Build option: define V74X139_ENC_MULTI_EN to add M1/M2.
module v74x139_enc
  import v74x139_enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 3
) (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic [3:0] I1_L,
  input  logic [3:0] I2_L,
  input  logic       ACK1,
  input  logic       ACK2,
  output logic       B1,
  output logic       A1,
  output logic       V1,
  output logic       B2,
  output logic       A2,
  output logic       V2
`ifdef V74X139_ENC_MULTI_EN
  ,
  output logic       M1,
  output logic       M2
`endif
);

  logic [CODE_W-1:0] code1, code2;

  v74x139_enc_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYC (STABLE_CYC)
  ) u_chan1 (
    .clk   (CLK),
    .rst_n (RESET_L),
    .req_l (I1_L),
    .ack   (ACK1),
    .code  (code1),
    .valid (V1)
`ifdef V74X139_ENC_MULTI_EN
    ,
    .multi (M1)
`endif
  );

  v74x139_enc_chan #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYC (STABLE_CYC)
  ) u_chan2 (
    .clk   (CLK),
    .rst_n (RESET_L),
    .req_l (I2_L),
    .ack   (ACK2),
    .code  (code2),
    .valid (V2)
`ifdef V74X139_ENC_MULTI_EN
    ,
    .multi (M2)
`endif
  );

  assign {B1, A1} = code1;
  assign {B2, A2} = code2;

endmodule

// File: tb/tb_v74x139_enc.sv
// tb_v74x139_enc
// Directed bench for v74x139_enc. A default instance (SYNC_STAGES=2,
// STABLE_CYC=3) covers the main behaviour; a second instance with
// SYNC_STAGES=1, STABLE_CYC=1 covers the minimum-latency build.
// Define V74X139_ENC_MULTI_EN to also check M1/M2.
module tb_v74x139_enc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i1_l, i2_l;
  logic       ack1, ack2;
  logic       b1, a1, v1, b2, a2, v2;
  logic [3:0] f_i1, f_i2;
  logic       f_ack1, f_ack2;
  logic       f_b1, f_a1, f_v1, f_b2, f_a2, f_v2;
`ifdef V74X139_ENC_MULTI_EN
  logic       m1, m2, f_m1, f_m2;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  v74x139_enc dut (
    .CLK(clk), .RESET_L(rst_n), .I1_L(i1_l), .I2_L(i2_l),
    .ACK1(ack1), .ACK2(ack2),
    .B1(b1), .A1(a1), .V1(v1), .B2(b2), .A2(a2), .V2(v2)
`ifdef V74X139_ENC_MULTI_EN
    , .M1(m1), .M2(m2)
`endif
  );

  v74x139_enc #(.SYNC_STAGES(1), .STABLE_CYC(1)) dut_fast (
    .CLK(clk), .RESET_L(rst_n), .I1_L(f_i1), .I2_L(f_i2),
    .ACK1(f_ack1), .ACK2(f_ack2),
    .B1(f_b1), .A1(f_a1), .V1(f_v1), .B2(f_b2), .A2(f_a2), .V2(f_v2)
`ifdef V74X139_ENC_MULTI_EN
    , .M1(f_m1), .M2(f_m2)
`endif
  );

  typedef struct {
    logic [3:0] in1;
    logic [3:0] in2;
    logic [1:0] code1;
    logic [1:0] code2;
    logic       multi1;
    logic       multi2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs
  // are sampled here, away from the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Acknowledge both channels of the default instance, then idle the inputs
  // long enough (sync depth + 1 edges) for RELEASE to return to IDLE.
  task automatic ack_and_release();
    ack1 = 1'b1; ack2 = 1'b1;
    tick();
    ack1 = 1'b0; ack2 = 1'b0;
    i1_l = 4'b1111; i2_l = 4'b1111;
    tick(3);
  endtask

  vec_t vecs[4];
  logic seen;

  initial begin
    // Expected codes: index of the highest-numbered 0 bit.
    vecs[0] = '{in1: 4'b1011, in2: 4'b0110, code1: 2'b10, code2: 2'b11, multi1: 1'b0, multi2: 1'b1};
    vecs[1] = '{in1: 4'b0111, in2: 4'b1110, code1: 2'b11, code2: 2'b00, multi1: 1'b0, multi2: 1'b0};
    vecs[2] = '{in1: 4'b1100, in2: 4'b0000, code1: 2'b01, code2: 2'b11, multi1: 1'b1, multi2: 1'b1};
    vecs[3] = '{in1: 4'b1110, in2: 4'b1101, code1: 2'b00, code2: 2'b01, multi1: 1'b0, multi2: 1'b0};

    // 1. Reset with all lines asserted: everything stays cleared.
    rst_n = 1'b0;
    i1_l = 4'b0000; i2_l = 4'b0000; ack1 = 1'b0; ack2 = 1'b0;
    f_i1 = 4'b1111; f_i2 = 4'b1111; f_ack1 = 1'b0; f_ack2 = 1'b0;
    tick(3);
    check("reset_v1", v1, 1'b0);
    check("reset_v2", v2, 1'b0);
    check("reset_ba1", {b1, a1}, 2'b00);
    check("reset_ba2", {b2, a2}, 2'b00);
    i1_l = 4'b1111; i2_l = 4'b1111;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen = seen | v1 | v2;
    end
    check("idle_no_valid", seen, 1'b0);

    // 2. Single request, ack, held request not re-reported, re-press.
    i1_l = 4'b1101;
    tick(5);
    check("t2_v1_before_edge6", v1, 1'b0);
    tick();
    check("t2_v1_edge6", v1, 1'b1);
    check("t2_code1", {b1, a1}, 2'b01);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    check("t2_v1_after_ack", v1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen = seen | v1;
    end
    check("t2_held_not_reported", seen, 1'b0);
    i1_l = 4'b1111;
    tick(3);
    i1_l = 4'b1101;
    tick(5);
    check("t2_repress_v1_early", v1, 1'b0);
    tick();
    check("t2_repress_v1", v1, 1'b1);
    check("t2_repress_code1", {b1, a1}, 2'b01);
    ack_and_release();

    // 3. Table: both channels driven on the same cycle, independent acks.
    for (int i = 0; i < 4; i++) begin
      i1_l = vecs[i].in1;
      i2_l = vecs[i].in2;
      tick(5);
      check($sformatf("t3_%0d_v_early", i), {v1, v2}, 2'b00);
      tick();
      check($sformatf("t3_%0d_v", i), {v1, v2}, 2'b11);
      check($sformatf("t3_%0d_code1", i), {b1, a1}, vecs[i].code1);
      check($sformatf("t3_%0d_code2", i), {b2, a2}, vecs[i].code2);
`ifdef V74X139_ENC_MULTI_EN
      check($sformatf("t3_%0d_m1", i), m1, vecs[i].multi1);
      check($sformatf("t3_%0d_m2", i), m2, vecs[i].multi2);
`endif
      // Ack channel 1 only: channel 2 must keep its report.
      ack1 = 1'b1;
      tick();
      ack1 = 1'b0;
      check($sformatf("t3_%0d_ack1_only", i), {v1, v2}, 2'b01);
`ifdef V74X139_ENC_MULTI_EN
      check($sformatf("t3_%0d_m1_clear", i), m1, 1'b0);
`endif
      ack_and_release();
      check($sformatf("t3_%0d_v_cleared", i), {v1, v2}, 2'b00);
    end

    // 4a. A 2-cycle glitch never qualifies.
    i1_l = 4'b1110;
    tick(2);
    i1_l = 4'b1111;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      seen = seen | v1;
    end
    check("t4_glitch_no_v1", seen, 1'b0);

    // 4b. Pattern changes mid-qualification: the count restarts on the new
    // pattern, so V rises 6 edges after the raw change (4 after it reaches
    // the synchronizer output).
    i1_l = 4'b1110;
    tick(2);
    i1_l = 4'b1011;
    tick(5);
    check("t4_restart_v1_early", v1, 1'b0);
    tick();
    check("t4_restart_v1", v1, 1'b1);
    check("t4_restart_code1", {b1, a1}, 2'b10);
    ack_and_release();

    // 5. Asynchronous reset while valid clears outputs before the next edge.
    i1_l = 4'b0111;
    tick(6);
    check("t5_v1_valid", v1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_v1_async_clear", v1, 1'b0);
    check("t5_code1_async_clear", {b1, a1}, 2'b00);
    i1_l = 4'b1111;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      seen = seen | v1;
    end
    check("t5_no_v1_after_reset", seen, 1'b0);

    // 6. Minimum-latency build: V on edge 3, joint ack, held ack.
    f_i1 = 4'b0111;
    f_i2 = 4'b1101;
    tick(2);
    check("t6_v_early", {f_v1, f_v2}, 2'b00);
    tick();
    check("t6_v_edge3", {f_v1, f_v2}, 2'b11);
    check("t6_code1", {f_b1, f_a1}, 2'b11);
    check("t6_code2", {f_b2, f_a2}, 2'b01);
    f_ack1 = 1'b1;
    f_ack2 = 1'b1;
    tick();
    check("t6_joint_ack", {f_v1, f_v2}, 2'b00);
    // Ack stays high and the requests stay held: no second report.
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | f_v1 | f_v2;
    end
    check("t6_held_ack_no_report", seen, 1'b0);
    f_ack1 = 1'b0;
    f_ack2 = 1'b0;
    f_i1 = 4'b1111;
    f_i2 = 4'b1111;
    tick(2);
    f_i1 = 4'b1011;
    tick(3);
    check("t6_rearm_v1", f_v1, 1'b1);
    check("t6_rearm_code1", {f_b1, f_a1}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
